// File: rtl/serial_subtractor_if.sv
// rtl/serial_subtractor_if.sv - start/done handshake with operand and result bundle
// o_overflow is present only when SUB_OVERFLOW_EN is defined.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             i_start;
    logic [WIDTH-1:0] i_minuend;
    logic [WIDTH-1:0] i_subtrahend;
    logic             o_busy;
    logic             o_done;
    logic [WIDTH-1:0] o_diff;
    logic             o_borrow;
`ifdef SUB_OVERFLOW_EN
    logic             o_overflow;
`endif

    modport master (
        output i_start, i_minuend, i_subtrahend,
`ifdef SUB_OVERFLOW_EN
        input  o_overflow,
`endif
        input  o_busy, o_done, o_diff, o_borrow
    );

    modport slave (
        input  i_start, i_minuend, i_subtrahend,
`ifdef SUB_OVERFLOW_EN
        output o_overflow,
`endif
        output o_busy, o_done, o_diff, o_borrow
    );
endinterface

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial LSB-first subtractor, one full-subtractor cell and one borrow flop
// Optional signed overflow flag enabled by defining SUB_OVERFLOW_EN.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    serial_subtractor_if.slave   bus
);
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic             br;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] diff_q;
    logic             borrow_q;
    logic             d;
    logic             br_next;
    logic             last_bit;
    logic             busy;
    logic             done;

    assign d        = a_sr[0] ^ b_sr[0] ^ br;
    assign br_next  = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br);
    assign last_bit = (cnt == CNT_W'(WIDTH - 1));

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (bus.i_start) state_next = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (last_bit) state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

`ifdef SUB_OVERFLOW_EN
    logic a_msb;
    logic b_msb;
    logic ovf_q;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            a_msb <= 1'b0;
            b_msb <= 1'b0;
            ovf_q <= 1'b0;
        end else if (state == IDLE && bus.i_start) begin
            a_msb <= bus.i_minuend[WIDTH-1];
            b_msb <= bus.i_subtrahend[WIDTH-1];
        end else if (state == RUN && last_bit) begin
            ovf_q <= (a_msb != b_msb) && (d != a_msb);
        end
    end

    assign bus.o_overflow = ovf_q;
`endif

    // a_sr doubles as the result register: difference bits enter at the MSB as operand bits leave the LSB.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state    <= IDLE;
            a_sr     <= '0;
            b_sr     <= '0;
            br       <= 1'b0;
            cnt      <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (bus.i_start) begin
                        a_sr <= bus.i_minuend;
                        b_sr <= bus.i_subtrahend;
                        br   <= 1'b0;
                        cnt  <= '0;
                    end
                end
                RUN: begin
                    a_sr <= {d, a_sr[WIDTH-1:1]};
                    b_sr <= {1'b0, b_sr[WIDTH-1:1]};
                    br   <= br_next;
                    cnt  <= cnt + 1'b1;
                    if (last_bit) begin
                        diff_q   <= {d, a_sr[WIDTH-1:1]};
                        borrow_q <= br_next;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.o_busy   = busy;
    assign bus.o_done   = done;
    assign bus.o_diff   = diff_q;
    assign bus.o_borrow = borrow_q;
endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial, LSB-first subtractor computing minuend − subtrahend over WIDTH clock cycles.
- Uses one full-subtractor cell (difference = a ^ b ^ borrow) and a single borrow flip-flop.
- Counterpart to the team's ripple adder cells: trades latency for area in datapaths that need subtraction.
- Start/done handshake to the controlling FSM; results held until the next operation completes.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 2..32.

Ports:
- i_clk  input  1  rising-edge clock
- i_rst_n  input  1  synchronous active-low reset
- i_start  input  1  start request; sampled only in IDLE
- i_minuend  input  WIDTH  operand A; captured on accepted start
- i_subtrahend  input  WIDTH  operand B; captured on accepted start
- o_busy  output  1  high while in RUN
- o_done  output  1  one-cycle completion pulse
- o_diff  output  WIDTH  A − B modulo 2^WIDTH
- o_borrow  output  1  unsigned borrow out (1 when A < B)
- o_overflow  output  1  signed overflow (present only with the optional feature)

Behaviour:
- Interface: one clock, i_clk. Reset i_rst_n is synchronous and active-low.
- Reset (i_rst_n=0 at a rising edge):
  - State goes to IDLE; internal shift registers, counter and borrow register clear.
  - o_busy=0, o_done=0, o_diff=0, o_borrow=0, o_overflow=0.
  - Reset takes priority over every other condition.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - o_busy=0.
  - If i_start=1 at an edge: load A_sr<=i_minuend, B_sr<=i_subtrahend, br<=0, cnt<=0, R_sr<=0; go to RUN.
  - Otherwise stay in IDLE.
- RUN (o_busy=1), per edge:
  - d = A_sr[0] ^ B_sr[0] ^ br
  - br <= (~A_sr[0] & B_sr[0]) | (~(A_sr[0] ^ B_sr[0]) & br)
  - R_sr <= {d, R_sr[WIDTH-1:1]}; A_sr and B_sr shift right by one; cnt <= cnt+1.
  - At the edge processing bit WIDTH-1 (cnt == WIDTH-1): load o_diff with the final shifted result and o_borrow with the final borrow; go to DONE.
- DONE:
  - o_done=1 for exactly one cycle; o_busy=0.
  - Go to IDLE unconditionally at the next edge.
- Latency: i_start sampled at edge k → o_done high during the cycle following edge k+WIDTH. Throughput is one operation per WIDTH+2 cycles.
- i_start while in RUN or DONE is ignored; no queuing.
- Operand inputs are don't-care after capture; changes during RUN have no effect.
- o_diff and o_borrow update only on entry to DONE and hold stable otherwise, including through IDLE.
- Reset asserted mid-RUN aborts the operation: no o_done pulse, and outputs return to 0.
- Arithmetic is unsigned modulo 2^WIDTH, e.g. 0 − 1 = all ones with o_borrow=1.
- Counter width is $clog2(WIDTH); no wrap occurs inside an operation.

Optional Feature:
- Macro: SUB_OVERFLOW_EN.
- Defined:
  - o_overflow port exists.
  - Captured at the accepted start: a_msb = i_minuend[WIDTH-1], b_msb = i_subtrahend[WIDTH-1].
  - On entry to DONE: o_overflow <= (a_msb != b_msb) && (d_final != a_msb), where d_final is the MSB difference bit. This is two's-complement overflow.
  - Reset value 0; holds like o_diff.
- Not defined:
  - o_overflow port and its MSB capture registers are absent.
  - All other behaviour is identical.

Test Plan:
- WIDTH=8, A=0x5A, B=0x23, start at edge k → o_busy high for edges k+1..k+8; o_done pulse after edge k+8; o_diff=0x37, o_borrow=0.
- A=0x00, B=0x01 → o_diff=0xFF, o_borrow=1; A=0xFF, B=0xFF → o_diff=0x00, o_borrow=0.
- SUB_OVERFLOW_EN defined, A=0x80, B=0x01 → o_diff=0x7F, o_borrow=0, o_overflow=1; then A=0x05, B=0x03 → o_overflow=0.
- Start A=0x10, B=0x01, then re-pulse i_start with A=0xAA, B=0x55 at RUN cycle 3 → second request ignored; result 0x0F, one o_done pulse only.
- Start A=0x40, B=0x20, assert i_rst_n=0 at RUN cycle 4 for one edge → no o_done; all outputs 0; a new start afterwards (A=0x09, B=0x04) completes normally with o_diff=0x05.
- Hold i_start=1 continuously → operations complete back-to-back every 10 cycles (WIDTH+2); o_diff holds the previous value until each DONE.
